// File: rtl/bus94_pkg.sv
// Shared types and constants for the bus_arb_94 arbiter/capture slice.
// Source indices follow the mux input order a..d.
package bus94_pkg;

   localparam int WORD_W = 9;

   localparam logic [1:0] SRC_A = 2'd0;
   localparam logic [1:0] SRC_B = 2'd1;
   localparam logic [1:0] SRC_C = 2'd2;
   localparam logic [1:0] SRC_D = 2'd3;

   typedef struct packed {
      logic [1:0]        src;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CAPT = 1'b1
   } cap_state_t;

   // FIFO pointers wrap at the configured depth rather than at the 2-bit limit
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr, input int depth);
      return (int'(ptr) == depth - 1) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick: the first set request at or above
// the pointer, wrapping modulo 4.
module rr_arb4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_rr_ptr,
   output logic [1:0] o_winner,
   output logic       o_any
);

   logic [1:0] w_idx;

   // Scan from the farthest offset down so the nearest requester overwrites last
   always_comb begin
      o_winner = i_rr_ptr;
      o_any    = |i_req;
      w_idx    = '0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = i_rr_ptr + 2'(k);
         if (i_req[w_idx]) o_winner = w_idx;
      end
   end

endmodule

// File: rtl/bus_arb_94.sv
// Round-robin arbiter driving the 4-input source mux, plus a capture FIFO that
// tags each captured mux word with the index of the requester that won it.
module bus_arb_94
   import bus94_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       req,
   output logic [3:0]       gnt,
   output logic [1:0]       mux_sel,
   output logic             mux_reset,
   input  logic [WIDTH-1:0] mux_y,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   output logic             out_valid,
   input  logic             out_ready
);

   cap_state_t  r_state;
   cap_state_t  w_state_next;

   logic [1:0]  r_rr_ptr;
   logic [1:0]  r_cap_src;
   logic [1:0]  r_mux_sel;
   logic        r_mux_reset;

   fifo_entry_t r_mem [4];
   fifo_entry_t r_out;
   logic [1:0]  r_rd_ptr;
   logic [1:0]  r_wr_ptr;
   logic [2:0]  r_count;

   logic [1:0]  w_winner;
   logic        w_any;
   logic        w_push;
   logic        w_pop;
   logic        w_space_ok;
   logic        w_grant;
   logic [1:0]  w_rd_next;
   logic [2:0]  w_count_next;
   fifo_entry_t w_push_entry;
   fifo_entry_t w_head_next;

   rr_arb4 u_rr_arb4 (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   assign w_push       = (r_state == ST_CAPT);
   assign w_pop        = out_valid && out_ready;
   assign w_space_ok   = (({1'b0, r_count} + 4'(w_push)) - 4'(w_pop)) < 4'(DEPTH);
   assign w_grant      = reset_n && w_any && w_space_ok;
   assign w_rd_next    = w_pop ? ptr_inc(r_rd_ptr, DEPTH) : r_rd_ptr;
   assign w_count_next = (r_count + 3'(w_push)) - 3'(w_pop);
   assign w_push_entry = '{src: r_cap_src, data: mux_y};

   assign gnt       = w_grant ? (4'b0001 << w_winner) : 4'b0000;
   assign mux_sel   = r_mux_sel;
   assign mux_reset = r_mux_reset;
   assign out_valid = (r_count != 3'd0);
   assign out_data  = r_out.data;
   assign out_src   = r_out.src;

   // Capture state register: a grant always schedules a capture on the following edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_grant) w_state_next = ST_CAPT;
         ST_CAPT: if (!w_grant) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Head register follows the post-update head; a word pushed into an empty
   // FIFO (or one that empties this edge) goes straight through to the output
   always_comb begin
      w_head_next = r_out;
      if (w_count_next != 3'd0) begin
         if (w_push && (w_rd_next == r_wr_ptr)) w_head_next = w_push_entry;
         else                                   w_head_next = r_mem[w_rd_next];
      end
   end

   // Mux control: select is held between grants, reset re-asserts when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mux_sel   <= 2'd0;
         r_mux_reset <= 1'b1;
         r_cap_src   <= 2'd0;
         r_rr_ptr    <= 2'd0;
      end else if (w_grant) begin
         r_mux_sel   <= w_winner;
         r_mux_reset <= 1'b0;
         r_cap_src   <= w_winner;
         r_rr_ptr    <= w_winner + 2'd1;
      end else begin
         r_mux_reset <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
         r_out    <= '0;
         r_rd_ptr <= 2'd0;
         r_wr_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
            r_wr_ptr        <= ptr_inc(r_wr_ptr, DEPTH);
         end
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         r_out    <= w_head_next;
      end
   end

endmodule

// File: tb/tb_bus_arb_94.sv
// Directed bench for bus_arb_94: per-cycle grant checks plus a scoreboard that
// pairs every expected captured word with the FIFO output handshake.
module tb_bus_arb_94;
   import bus94_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [8:0] DATA_A = 9'h011;
   localparam logic [8:0] DATA_B = 9'h022;
   localparam logic [8:0] DATA_C = 9'h0A5;
   localparam logic [8:0] DATA_D = 9'h1FF;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] mux_sel;
   logic       mux_reset;
   logic [8:0] mux_y;
   logic [8:0] out_data;
   logic [1:0] out_src;
   logic       out_valid;
   logic       out_ready = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;
   fifo_entry_t sbQ[$];

   always #5 clk = ~clk;

   bus_arb_94 #(.WIDTH(9), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .gnt       (gnt),
      .mux_sel   (mux_sel),
      .mux_reset (mux_reset),
      .mux_y     (mux_y),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Behavioural model of the source mux feeding the capture stage
   always_comb begin
      mux_y = 9'h000;
      if (!mux_reset) begin
         case (mux_sel)
            2'd0: mux_y = DATA_A;
            2'd1: mux_y = DATA_B;
            2'd2: mux_y = DATA_C;
            default: mux_y = DATA_D;
         endcase
      end
   end

   function automatic logic [1:0] srcOf(input logic [3:0] oneHot);
      case (oneHot)
         4'b0001: return SRC_A;
         4'b0010: return SRC_B;
         4'b0100: return SRC_C;
         default: return SRC_D;
      endcase
   endfunction

   function automatic logic [8:0] dataOf(input logic [1:0] src);
      case (src)
         2'd0: return DATA_A;
         2'd1: return DATA_B;
         2'd2: return DATA_C;
         default: return DATA_D;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, check the combinational grant, queue the word it implies
   task automatic applyStimulus(input logic [3:0] reqV, input logic readyV,
                                input logic [3:0] expGnt, input string name);
      logic [1:0] s;
      req       = reqV;
      out_ready = readyV;
      #1;
      checkOutput(name, 32'(gnt), 32'(expGnt));
      if (expGnt != 4'b0000) begin
         s = srcOf(expGnt);
         sbQ.push_back('{src: s, data: dataOf(s)});
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted head word must match the oldest expected entry
   always @(negedge clk) begin
      fifo_entry_t e;
      if (reset_n) begin
         checkOutput("count_le_depth", 32'(dut.r_count <= 3'(DEPTH)), 32'd1);
         if (out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_pop: got src %0d data %0h, expected no word", out_src, out_data);
            end else begin
               e = sbQ.pop_front();
               checkOutput("sb_src", 32'(out_src), 32'(e.src));
               checkOutput("sb_data", 32'(out_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      // Reset values with all requests asserted
      reset_n   = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      #12;
      checkOutput("rst_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_mux_sel", 32'(mux_sel), 32'h0);
      checkOutput("rst_mux_reset", 32'(mux_reset), 32'h1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_out_data", 32'(out_data), 32'h0);
      checkOutput("rst_out_src", 32'(out_src), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Full rotation with everyone requesting and the consumer always ready
      applyStimulus(4'b1111, 1'b1, 4'b0001, "rot_gnt0");
      applyStimulus(4'b1111, 1'b1, 4'b0010, "rot_gnt1");
      applyStimulus(4'b1111, 1'b1, 4'b0100, "rot_gnt2");
      applyStimulus(4'b1111, 1'b1, 4'b1000, "rot_gnt3");
      applyStimulus(4'b1111, 1'b1, 4'b0001, "rot_gnt4");
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 4'b0000, "rot_idle");

      // Single request from c: select, capture latency and mux reset release
      applyStimulus(4'b0100, 1'b1, 4'b0100, "single_gnt");
      checkOutput("single_mux_sel", 32'(mux_sel), 32'd2);
      checkOutput("single_mux_reset_lo", 32'(mux_reset), 32'd0);
      req = 4'b0000;
      @(posedge clk);
      #1;
      checkOutput("single_valid", 32'(out_valid), 32'd1);
      checkOutput("single_data", 32'(out_data), 32'h0A5);
      checkOutput("single_src", 32'(out_src), 32'd2);
      checkOutput("single_mux_reset_hi", 32'(mux_reset), 32'd1);
      for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 1'b1, 4'b0000, "single_idle");

      // Stall: only DEPTH grants while the consumer is not ready
      applyStimulus(4'b1111, 1'b0, 4'b1000, "stall_gnt0");
      applyStimulus(4'b1111, 1'b0, 4'b0001, "stall_gnt1");
      for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, 4'b0000, "stall_blocked");
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_src", 32'(out_src), 32'd3);
      checkOutput("stall_data", 32'(out_data), 32'h1FF);
      checkOutput("stall_count", 32'(dut.r_count), 32'd2);

      // Release: one new grant per pop, ordering kept through full-FIFO draining
      applyStimulus(4'b1111, 1'b1, 4'b0010, "resume_gnt0");
      checkOutput("resume_head_adv", 32'(out_src), 32'd0);
      applyStimulus(4'b1111, 1'b1, 4'b0100, "resume_gnt1");
      applyStimulus(4'b1111, 1'b1, 4'b1000, "resume_gnt2");
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 4'b0000, "resume_idle");

      // Reset while a capture is pending and one word sits in the FIFO
      applyStimulus(4'b0011, 1'b0, 4'b0001, "mid_gnt0");
      applyStimulus(4'b0011, 1'b0, 4'b0010, "mid_gnt1");
      checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      sbQ.delete();
      checkOutput("mid_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_mux_reset", 32'(mux_reset), 32'd1);
      checkOutput("mid_mux_sel", 32'(mux_sel), 32'd0);
      checkOutput("mid_gnt", 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      applyStimulus(4'b0110, 1'b1, 4'b0010, "post_rst_gnt");
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 4'b0000, "post_rst_idle");

      // Pointer wrap with sparse requesters
      applyStimulus(4'b1000, 1'b1, 4'b1000, "wrap_gnt3");
      applyStimulus(4'b1001, 1'b1, 4'b0001, "wrap_gnt0");
      applyStimulus(4'b1001, 1'b1, 4'b1000, "wrap_gnt3b");
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 4'b0000, "wrap_idle");

      checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
